uvmt_cvmcu_obi_arb: RTL and testbench

UVMT_CVMCU_OBI_ARB -- requirements
Module: uvmt_cvmcu_obi_arb

---
 rtl/uvmt_cvmcu_obi_arb.sv | 149 ++++++++++++++
 tb/tb_uvmt_cvmcu_obi_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_cvmcu_obi_arb.sv
// Two-master round-robin OBI arbiter in front of a single shared slave port.
// A route FIFO remembers which master owns each outstanding response.
module uvmt_cvmcu_obi_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,

    input  logic                           m0_req,
    input  logic [ADDR_W-1:0]              m0_addr,
    input  logic                           m0_we,
    input  logic [DATA_W/8-1:0]            m0_be,
    input  logic [DATA_W-1:0]              m0_wdata,
    output logic                           m0_gnt,
    output logic                           m0_rvalid,

    input  logic                           m1_req,
    input  logic [ADDR_W-1:0]              m1_addr,
    input  logic                           m1_we,
    input  logic [DATA_W/8-1:0]            m1_be,
    input  logic [DATA_W-1:0]              m1_wdata,
    output logic                           m1_gnt,
    output logic                           m1_rvalid,

    output logic [DATA_W-1:0]              m_rdata,

    output logic                           s_req,
    output logic [ADDR_W-1:0]              s_addr,
    output logic                           s_we,
    output logic [DATA_W/8-1:0]            s_be,
    output logic [DATA_W-1:0]              s_wdata,
    input  logic                           s_gnt,
    input  logic                           s_rvalid,
    input  logic [DATA_W-1:0]              s_rdata,

    output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt,
    output logic                           err_o
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SLOTS = 1 << PTR_W;

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } mst_e;

    mst_e              prio;
    mst_e              lock_id;
    mst_e              sel;
    mst_e              head_id;
    logic              lock;
    logic              sel_req;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [SLOTS-1:0]  route_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A stalled request pins the selection so the forwarded request cannot change before its grant.
    always_comb begin
        sel = prio;
        if (lock) begin
            sel = lock_id;
        end else if (m0_req && !m1_req) begin
            sel = MST0;
        end else if (m1_req && !m0_req) begin
            sel = MST1;
        end
    end

    always_comb begin
        sel_req = (sel == MST1) ? m1_req : m0_req;
        full    = (count == CNT_W'(MAX_OUT));
        empty   = (count == '0);
        s_req   = reset_n && sel_req && !full;
        push    = s_req && s_gnt;
        pop     = reset_n && s_rvalid && !empty;
        head_id = mst_e'(route_id[rd_ptr]);
    end

    always_comb begin
        s_addr  = (sel == MST1) ? m1_addr  : m0_addr;
        s_we    = (sel == MST1) ? m1_we    : m0_we;
        s_be    = (sel == MST1) ? m1_be    : m0_be;
        s_wdata = (sel == MST1) ? m1_wdata : m0_wdata;
    end

    always_comb begin
        m0_gnt    = push && (sel == MST0);
        m1_gnt    = push && (sel == MST1);
        m0_rvalid = pop && (head_id == MST0);
        m1_rvalid = pop && (head_id == MST1);
        m_rdata   = s_rdata;
    end

    assign out_cnt = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio    <= MST0;
            lock    <= 1'b0;
            lock_id <= MST0;
        end else if (push) begin
            lock <= 1'b0;
            prio <= (sel == MST0) ? MST1 : MST0;
        end else if (s_req) begin
            lock    <= 1'b1;
            lock_id <= sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            route_id <= '0;
            err_o    <= 1'b0;
        end else begin
            if (push) begin
                route_id[wr_ptr] <= sel;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (s_rvalid && empty) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uvmt_cvmcu_obi_arb.sv
// Directed and randomized checks of the OBI arbiter against a queue-based reference model.
module tb_uvmt_cvmcu_obi_arb;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 4;
    localparam int BE_W    = DATA_W / 8;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic              m0_we, m1_we;
    logic [BE_W-1:0]   m0_be, m1_be;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              s_req;
    logic [ADDR_W-1:0] s_addr;
    logic              s_we;
    logic [BE_W-1:0]   s_be;
    logic [DATA_W-1:0] s_wdata;
    logic              s_gnt, s_rvalid;
    logic [DATA_W-1:0] s_rdata;
    logic [CNT_W-1:0]  out_cnt;
    logic              err_o;

    uvmt_cvmcu_obi_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_we    (m0_we),
        .m0_be    (m0_be),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_we    (m1_we),
        .m1_be    (m1_be),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_we     (s_we),
        .s_be     (s_be),
        .s_wdata  (s_wdata),
        .s_gnt    (s_gnt),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata),
        .out_cnt  (out_cnt),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of owners of outstanding transactions plus arbitration history.
    bit q[$];
    bit last_gnt;
    bit held_v;
    bit held_id;
    bit err_m;
    bit did;
    bit who;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_gnt = 1'b1;
        held_v   = 1'b0;
        held_id  = 1'b0;
        err_m    = 1'b0;
    endtask

    task automatic clear_inputs();
        m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_be = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_be = '0; m1_wdata = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    endtask

    // Called in the first half of a cycle; checks at the falling edge, updates the model at the rising edge.
    task automatic step();
        bit [1:0] req;
        bit       cand;
        bit       sreq;
        bit       has_head;
        bit       head;
        @(negedge clk);
        req = {m1_req, m0_req};
        if (held_v)             cand = held_id;
        else if (req == 2'b11)  cand = ~last_gnt;
        else                    cand = req[1];
        sreq     = req[cand] && (q.size() < MAX_OUT);
        has_head = (q.size() > 0);
        head     = 1'b0;
        if (has_head) head = q[0];
        chk("s_req",  64'(s_req),  64'(sreq));
        chk("m0_gnt", 64'(m0_gnt), 64'(sreq && s_gnt && !cand));
        chk("m1_gnt", 64'(m1_gnt), 64'(sreq && s_gnt && cand));
        if (sreq) begin
            chk("s_addr",  64'(s_addr),  64'(cand ? m1_addr  : m0_addr));
            chk("s_we",    64'(s_we),    64'(cand ? m1_we    : m0_we));
            chk("s_be",    64'(s_be),    64'(cand ? m1_be    : m0_be));
            chk("s_wdata", 64'(s_wdata), 64'(cand ? m1_wdata : m0_wdata));
        end
        chk("m0_rvalid", 64'(m0_rvalid), 64'(s_rvalid && has_head && !head));
        chk("m1_rvalid", 64'(m1_rvalid), 64'(s_rvalid && has_head && head));
        chk("m_rdata",   64'(m_rdata),   64'(s_rdata));
        chk("out_cnt",   64'(out_cnt),   64'(q.size()));
        chk("err_o",     64'(err_o),     64'(err_m));
        @(posedge clk);
        if (s_rvalid) begin
            if (has_head) void'(q.pop_front());
            else          err_m = 1'b1;
        end
        if (sreq && s_gnt) begin
            q.push_back(cand);
            last_gnt = cand;
            held_v   = 1'b0;
        end else if (sreq) begin
            held_v  = 1'b1;
            held_id = cand;
        end
        did = sreq && s_gnt;
        who = cand;
        #1;
    endtask

    task automatic drain(input int n);
        s_rvalid = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_rdata = $urandom;
            step();
        end
        s_rvalid = 1'b0;
    endtask

    task automatic pulse_reset();
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rstp_cnt",  64'(out_cnt), 64'd0);
        chk("rstp_err",  64'(err_o),   64'd0);
        chk("rstp_sreq", 64'(s_req),   64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] addrs [3];
        addrs[0] = 32'h1A10_0000;
        addrs[1] = 32'h0000_0004;
        addrs[2] = 32'h0000_0008;

        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_s_req",  64'(s_req),     64'd0);
        chk("rst_m0_gnt", 64'(m0_gnt),    64'd0);
        chk("rst_m1_gnt", 64'(m1_gnt),    64'd0);
        chk("rst_m0_rv",  64'(m0_rvalid), 64'd0);
        chk("rst_m1_rv",  64'(m1_rvalid), 64'd0);
        chk("rst_cnt",    64'(out_cnt),   64'd0);
        chk("rst_err",    64'(err_o),     64'd0);
        chk("rst_rdata",  64'(m_rdata),   64'hDEAD_BEEF);
        clear_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single master, three reads
        s_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m0_req = 1'b1; m0_we = 1'b0; m0_be = '1; m0_addr = addrs[k];
            #1;
            chk("t1_gnt",  64'(m0_gnt), 64'd1);
            chk("t1_addr", 64'(s_addr), 64'(addrs[k]));
            step();
            chk("t1_cnt_up", 64'(out_cnt), 64'(k + 1));
        end
        m0_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_rvalid = 1'b1;
            s_rdata  = $urandom;
            #1;
            chk("t1_rv0", 64'(m0_rvalid), 64'd1);
            chk("t1_rv1", 64'(m1_rvalid), 64'd0);
            chk("t1_rdata", 64'(m_rdata), 64'(s_rdata));
            step();
            chk("t1_cnt_dn", 64'(out_cnt), 64'(2 - k));
        end
        s_rvalid = 1'b0;

        // Contention from reset
        pulse_reset();
        m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1;
        m0_addr = 32'h1A10_1000; m1_addr = 32'h1A10_2000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_granted", 64'(did), 64'd1);
            chk("t2_order",   64'(who), 64'(i % 2));
        end
        m0_req = 1'b0; m1_req = 1'b0;
        drain(4);
        chk("t2_empty", 64'(out_cnt), 64'd0);

        // Stall and lock
        m1_req = 1'b1; m1_addr = 32'h1A10_0100; s_gnt = 1'b0;
        step();
        m0_req = 1'b1; m0_addr = 32'h1A10_0200;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t3_addr_held", 64'(s_addr), 64'h1A10_0100);
            chk("t3_no_gnt0",   64'(m0_gnt), 64'd0);
            step();
        end
        s_gnt = 1'b1;
        #1;
        chk("t3_first_m1", 64'(m1_gnt), 64'd1);
        step();
        chk("t3_first_who", 64'(who), 64'd1);
        #1;
        chk("t3_next_m0", 64'(m0_gnt), 64'd1);
        step();
        chk("t3_next_who", 64'(who), 64'd0);
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0;
        drain(2);

        // Full
        s_gnt = 1'b1; m0_req = 1'b1;
        for (int i = 0; i < MAX_OUT; i++) begin
            m0_addr = $urandom;
            step();
        end
        m1_req = 1'b1;
        #1;
        chk("t4_full_sreq", 64'(s_req),   64'd0);
        chk("t4_full_g0",   64'(m0_gnt),  64'd0);
        chk("t4_full_g1",   64'(m1_gnt),  64'd0);
        chk("t4_full_cnt",  64'(out_cnt), 64'(MAX_OUT));
        step();
        s_rvalid = 1'b1;
        #1;
        chk("t4_pop_sreq", 64'(s_req), 64'd0);
        step();
        s_rvalid = 1'b0;
        #1;
        chk("t4_after_cnt",  64'(out_cnt), 64'(MAX_OUT - 1));
        chk("t4_after_sreq", 64'(s_req),   64'd1);
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        drain(MAX_OUT);
        chk("t4_empty", 64'(out_cnt), 64'd0);

        // Unexpected response, then reset with work outstanding
        s_gnt = 1'b0; s_rvalid = 1'b1;
        #1;
        chk("t5_rv0", 64'(m0_rvalid), 64'd0);
        chk("t5_rv1", 64'(m1_rvalid), 64'd0);
        step();
        s_rvalid = 1'b0;
        chk("t5_err", 64'(err_o), 64'd1);
        m0_req = 1'b1; s_gnt = 1'b1;
        step();
        step();
        chk("t5_cnt2", 64'(out_cnt), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_cnt",  64'(out_cnt), 64'd0);
        chk("t5_rst_err",  64'(err_o),   64'd0);
        chk("t5_rst_sreq", 64'(s_req),   64'd0);
        chk("t5_rst_gnt",  64'(m0_gnt),  64'd0);
        model_reset();
        clear_inputs();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        s_rvalid = 1'b1;
        step();
        s_rvalid = 1'b0;
        chk("t5_late_err", 64'(err_o), 64'd1);
        pulse_reset();

        // Simultaneous push and pop
        s_gnt = 1'b1; m1_req = 1'b1;
        step();
        m1_req = 1'b0; m0_req = 1'b1;
        step();
        chk("t6_cnt2", 64'(out_cnt), 64'd2);
        m0_req = 1'b0; m1_req = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        chk("t6_rv_old", 64'(m1_rvalid), 64'd1);
        chk("t6_rv_m0",  64'(m0_rvalid), 64'd0);
        chk("t6_gnt",    64'(m1_gnt),    64'd1);
        step();
        chk("t6_cnt_same", 64'(out_cnt), 64'd2);
        m1_req = 1'b0; s_gnt = 1'b0;
        #1;
        chk("t6_next_m0", 64'(m0_rvalid), 64'd1);
        step();
        #1;
        chk("t6_new_m1", 64'(m1_rvalid), 64'd1);
        step();
        s_rvalid = 1'b0;
        chk("t6_empty", 64'(out_cnt), 64'd0);

        // Randomized traffic; a stalled master keeps its request stable until granted
        for (int n = 0; n < 400; n++) begin
            if (held_v && !held_id) begin
                m0_req = 1'b1;
            end else begin
                m0_req   = ($urandom_range(0, 2) != 0);
                m0_addr  = $urandom;
                m0_we    = 1'($urandom_range(0, 1));
                m0_be    = BE_W'($urandom);
                m0_wdata = $urandom;
            end
            if (held_v && held_id) begin
                m1_req = 1'b1;
            end else begin
                m1_req   = ($urandom_range(0, 2) != 0);
                m1_addr  = $urandom;
                m1_we    = 1'($urandom_range(0, 1));
                m1_be    = BE_W'($urandom);
                m1_wdata = $urandom;
            end
            s_gnt    = ($urandom_range(0, 9) < 6);
            s_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
